ctrl_path_pipe: RTL and testbench
=================================

# ctrl_path_pipe

Parametrised control-signal pipeline for the pipelined processor. It carries decoded control from Decode through Execute, a configurable number of Memory stages, and Writeback. It holds the NZCV flag register and evaluates all 15 ARM condition codes in Execute. It adds per-instruction valid tracking, Execute-stage stall, destination-tag tracking for the hazard unit, and retire/squash counters.

## Interface
- MEM_STAGES, 1, number of Memory pipeline stages between E and W (1..4)
- ALU_CTRL_W, 2, width of ALU control field
- CNT_W, 16, width of retire/squash counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- StallE  in  1  hold D/E register
- FlushE  in  1  load bubble into D/E register
- ValidD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoded control, Decode stage
- ALUControlD  in  ALU_CTRL_W  ALU operation
- FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V
- CondD  in  4  condition field
- WA3D  in  4  destination register tag
- ALUFlags  in  4  {N,Z,C,V} from the ALU, Execute stage
- ALUSrcE, MemtoRegE, RegWriteE  out  1  E-stage control (RegWriteE is pre-condition, for the hazard unit)
- ALUControlE  out  ALU_CTRL_W
- WA3E  out  4
- CondExE  out  1  condition passed and E valid
- BranchTakenE  out  1  BranchE & CondExE & ~StallE
- RegWriteMv  out  MEM_STAGES  RegWrite of each M stage; bit 0 = first
- WA3Mv  out  4*MEM_STAGES  tags of each M stage; [3:0] = first
- RegWriteM, MemWriteM, MemtoRegM  out  1  first M stage
- RegWriteW, MemtoRegW, PCSrcW  out  1  Writeback stage
- WA3W  out  4
- FlagsQ  out  4  flag register {N,Z,C,V}
- RetireCount, SquashCount  out  CNT_W  counters

## Operation
- D/E register:
  - reset → all zero.
  - Else FlushE → bubble (all fields 0, valid 0). FlushE beats StallE.
  - Else StallE → hold.
  - Else load D inputs.
- Condition codes (on FlagsQ, never on ALUFlags of the same instruction):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F never, evaluates 0.
- CondExE = ValidE & condition result.
- Gating: PCSrc, RegWrite, MemWrite, Branch and FlagWrite are each ANDed with CondExE before leaving E. MemtoReg and WA3 pass ungated.
- Flags: on an edge with CondExE & ~StallE:
  - FlagWriteE[1] → FlagsQ[3:2] ← ALUFlags[3:2].
  - FlagWriteE[0] → FlagsQ[1:0] ← ALUFlags[1:0].
  - Otherwise FlagsQ holds. Reset value 0000.
- Stall downstream: when StallE=1 and FlushE=0, E→M1 loads a bubble, and flags and counters do not update from E. Later stages keep advancing.
- M chain: M1..M_MEM_STAGES shift every cycle, never stalled. Each stage holds {valid, PCSrc, RegWrite, MemtoReg, MemWrite, WA3}. The last M stage feeds the W register.
- Counters:
  - RetireCount +1 on each edge where W valid=1.
  - SquashCount +1 on each edge where ValidE & ~CondExE & ~StallE.
  - Both wrap modulo 2^CNT_W. Reset to 0.
- Reset: all outputs 0 on the cycle after reset is sampled high. Reset mid-operation discards every in-flight instruction with no counter update.

## Timing
- D inputs sampled at edge k → E outputs valid after k.
- M1 after k+1.
- W after k+1+MEM_STAGES; MEM_STAGES=1 gives W after k+2.
- BranchTakenE and CondExE are combinational within the E cycle.
- FlagsQ updates at the edge that ends the E cycle, so the next instruction in E sees the new flags (back-to-back CMP then BEQ is legal).
- No combinational path from any D input to any output.

## Test plan
- Reset then ALU op (ValidD=1, RegWriteD=1, CondD=E, WA3D=5), MEM_STAGES=1 → RegWriteE=1 after edge 1, RegWriteM=1 after edge 2, RegWriteW=1 and WA3W=5 after edge 3, RetireCount=1 after edge 4.
- CMP (FlagWriteD=11, ALUFlags=0100) then BEQ (CondD=0, BranchD=1) → FlagsQ=0100 and BranchTakenE=1 while BEQ is in E. Repeat with ALUFlags=0000 → BranchTakenE=0 and SquashCount=1.
- Condition sweep: all 16 CondD values × all 16 FlagsQ values → CondExE matches the table. CondD=F always gives 0.
- StallE=1 for 2 cycles with a valid instruction in E → E outputs held, two bubbles enter M1, FlagsQ unchanged, instruction retires once. StallE=1 with FlushE=1 → bubble in E.
- MEM_STAGES=3 with WA3D=7 → RegWriteMv walks 001, 010, 100 on successive cycles with WA3Mv tracking. W is reached 4 edges after E.
- Reset asserted while 3 instructions are in flight → all outputs, FlagsQ and counters read 0 the next cycle. No retire is counted.

Source files
------------

// File: rtl/ctrl_path_pipe.sv
// Decoded-control pipeline D -> E -> M1..Mn -> W with the NZCV flag register,
// ARM condition evaluation in Execute, hazard tags and retire/squash counters.
module ctrl_path_pipe #(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned ALU_CTRL_W = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StallE,
  input  logic                    FlushE,
  input  logic                    ValidD,
  input  logic                    PCSrcD,
  input  logic                    RegWriteD,
  input  logic                    MemtoRegD,
  input  logic                    MemWriteD,
  input  logic                    BranchD,
  input  logic                    ALUSrcD,
  input  logic [ALU_CTRL_W-1:0]   ALUControlD,
  input  logic [1:0]              FlagWriteD,
  input  logic [3:0]              CondD,
  input  logic [3:0]              WA3D,
  input  logic [3:0]              ALUFlags,
  output logic                    ALUSrcE,
  output logic                    MemtoRegE,
  output logic                    RegWriteE,
  output logic [ALU_CTRL_W-1:0]   ALUControlE,
  output logic [3:0]              WA3E,
  output logic                    CondExE,
  output logic                    BranchTakenE,
  output logic [MEM_STAGES-1:0]   RegWriteMv,
  output logic [4*MEM_STAGES-1:0] WA3Mv,
  output logic                    RegWriteM,
  output logic                    MemWriteM,
  output logic                    MemtoRegM,
  output logic                    RegWriteW,
  output logic                    MemtoRegW,
  output logic                    PCSrcW,
  output logic [3:0]              WA3W,
  output logic [3:0]              FlagsQ,
  output logic [CNT_W-1:0]        RetireCount,
  output logic [CNT_W-1:0]        SquashCount
);

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned LAST_M = MEM_STAGES - 1;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Execute-stage control register
  logic                  r_valid_e;
  logic                  r_pcsrc_e;
  logic                  r_regwrite_e;
  logic                  r_memtoreg_e;
  logic                  r_memwrite_e;
  logic                  r_branch_e;
  logic                  r_alusrc_e;
  logic [ALU_CTRL_W-1:0] r_aluctrl_e;
  logic [1:0]            r_flagwrite_e;
  logic [3:0]            r_cond_e;
  logic [TAG_W-1:0]      r_wa3_e;

  // Memory-stage chain, bit/slice 0 is the first M stage
  logic [MEM_STAGES-1:0]       r_m_valid;
  logic [MEM_STAGES-1:0]       r_m_pcsrc;
  logic [MEM_STAGES-1:0]       r_m_regwrite;
  logic [MEM_STAGES-1:0]       r_m_memtoreg;
  logic [TAG_W*MEM_STAGES-1:0] r_m_wa3;
  logic                        r_memwrite_m;

  logic             r_valid_w;
  logic             r_pcsrc_w;
  logic             r_regwrite_w;
  logic             r_memtoreg_w;
  logic [TAG_W-1:0] r_wa3_w;

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_squash_cnt;

  logic             w_flag_n;
  logic             w_flag_z;
  logic             w_flag_c;
  logic             w_flag_v;
  logic             w_cond_ok;
  logic             w_condex;
  logic             w_m1_bubble;
  logic             w_m1_valid;
  logic             w_m1_pcsrc;
  logic             w_m1_regwrite;
  logic             w_m1_memtoreg;
  logic             w_m1_memwrite;
  logic [TAG_W-1:0] w_m1_wa3;
  logic [1:0]       w_flagwrite;

  // D/E register: flush wins over stall
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_valid_e     <= 1'b0;
      r_pcsrc_e     <= 1'b0;
      r_regwrite_e  <= 1'b0;
      r_memtoreg_e  <= 1'b0;
      r_memwrite_e  <= 1'b0;
      r_branch_e    <= 1'b0;
      r_alusrc_e    <= 1'b0;
      r_aluctrl_e   <= '0;
      r_flagwrite_e <= 2'b00;
      r_cond_e      <= 4'h0;
      r_wa3_e       <= '0;
    end else if (!StallE) begin
      r_valid_e     <= ValidD;
      r_pcsrc_e     <= PCSrcD;
      r_regwrite_e  <= RegWriteD;
      r_memtoreg_e  <= MemtoRegD;
      r_memwrite_e  <= MemWriteD;
      r_branch_e    <= BranchD;
      r_alusrc_e    <= ALUSrcD;
      r_aluctrl_e   <= ALUControlD;
      r_flagwrite_e <= FlagWriteD;
      r_cond_e      <= CondD;
      r_wa3_e       <= WA3D;
    end
  end

  assign {w_flag_n, w_flag_z, w_flag_c, w_flag_v} = r_flags;

  // Condition evaluation uses the committed flags, never the in-flight ALU result
  always_comb begin
    w_cond_ok = 1'b0;
    case (r_cond_e)
      COND_EQ: w_cond_ok = w_flag_z;
      COND_NE: w_cond_ok = ~w_flag_z;
      COND_CS: w_cond_ok = w_flag_c;
      COND_CC: w_cond_ok = ~w_flag_c;
      COND_MI: w_cond_ok = w_flag_n;
      COND_PL: w_cond_ok = ~w_flag_n;
      COND_VS: w_cond_ok = w_flag_v;
      COND_VC: w_cond_ok = ~w_flag_v;
      COND_HI: w_cond_ok = w_flag_c & ~w_flag_z;
      COND_LS: w_cond_ok = ~w_flag_c | w_flag_z;
      COND_GE: w_cond_ok = (w_flag_n == w_flag_v);
      COND_LT: w_cond_ok = (w_flag_n != w_flag_v);
      COND_GT: w_cond_ok = ~w_flag_z & (w_flag_n == w_flag_v);
      COND_LE: w_cond_ok = w_flag_z | (w_flag_n != w_flag_v);
      COND_AL: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_condex    = r_valid_e & w_cond_ok;
  assign w_flagwrite = r_flagwrite_e & {2{w_condex}};

  // A stalled E stage sends a bubble into M1 unless it is being flushed
  assign w_m1_bubble   = StallE & ~FlushE;
  assign w_m1_valid    = r_valid_e & ~w_m1_bubble;
  assign w_m1_pcsrc    = r_pcsrc_e & w_condex & ~w_m1_bubble;
  assign w_m1_regwrite = r_regwrite_e & w_condex & ~w_m1_bubble;
  assign w_m1_memwrite = r_memwrite_e & w_condex & ~w_m1_bubble;
  assign w_m1_memtoreg = r_memtoreg_e & ~w_m1_bubble;
  assign w_m1_wa3      = w_m1_bubble ? '0 : r_wa3_e;

  // M chain shifts every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid    <= '0;
      r_m_pcsrc    <= '0;
      r_m_regwrite <= '0;
      r_m_memtoreg <= '0;
      r_m_wa3      <= '0;
      r_memwrite_m <= 1'b0;
    end else begin
      r_m_valid[0]          <= w_m1_valid;
      r_m_pcsrc[0]          <= w_m1_pcsrc;
      r_m_regwrite[0]       <= w_m1_regwrite;
      r_m_memtoreg[0]       <= w_m1_memtoreg;
      r_m_wa3[TAG_W-1:0]    <= w_m1_wa3;
      r_memwrite_m          <= w_m1_memwrite;
      for (int i = 1; i < int'(MEM_STAGES); i++) begin
        r_m_valid[i]                <= r_m_valid[i-1];
        r_m_pcsrc[i]                <= r_m_pcsrc[i-1];
        r_m_regwrite[i]             <= r_m_regwrite[i-1];
        r_m_memtoreg[i]             <= r_m_memtoreg[i-1];
        r_m_wa3[i*TAG_W +: TAG_W]   <= r_m_wa3[(i-1)*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_w    <= 1'b0;
      r_pcsrc_w    <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_wa3_w      <= '0;
    end else begin
      r_valid_w    <= r_m_valid[LAST_M];
      r_pcsrc_w    <= r_m_pcsrc[LAST_M];
      r_regwrite_w <= r_m_regwrite[LAST_M];
      r_memtoreg_w <= r_m_memtoreg[LAST_M];
      r_wa3_w      <= r_m_wa3[LAST_M*TAG_W +: TAG_W];
    end
  end

  // Flags commit at the end of the E cycle so the next instruction sees them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'h0;
    end else if (!StallE) begin
      if (w_flagwrite[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagwrite[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_cnt <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (r_valid_w) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (r_valid_e && !w_condex && !StallE) r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign ALUSrcE      = r_alusrc_e;
  assign MemtoRegE    = r_memtoreg_e;
  assign RegWriteE    = r_regwrite_e;
  assign ALUControlE  = r_aluctrl_e;
  assign WA3E         = r_wa3_e;
  assign CondExE      = w_condex;
  assign BranchTakenE = r_branch_e & w_condex & ~StallE;
  assign RegWriteMv   = r_m_regwrite;
  assign WA3Mv        = r_m_wa3;
  assign RegWriteM    = r_m_regwrite[0];
  assign MemWriteM    = r_memwrite_m;
  assign MemtoRegM    = r_m_memtoreg[0];
  assign RegWriteW    = r_regwrite_w;
  assign MemtoRegW    = r_memtoreg_w;
  assign PCSrcW       = r_pcsrc_w;
  assign WA3W         = r_wa3_w;
  assign FlagsQ       = r_flags;
  assign RetireCount  = r_retire_cnt;
  assign SquashCount  = r_squash_cnt;

endmodule

// File: tb/tb_ctrl_path_pipe.sv
// Bench for ctrl_path_pipe: two instances (1 and 3 memory stages) driven in lockstep,
// checked every cycle against a history-based model plus directed literal checks.
module tb_ctrl_path_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, StallE, FlushE;
  logic       ValidD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWriteD;
  logic [3:0] CondD, WA3D, ALUFlags;

  logic        a_ALUSrcE, a_MemtoRegE, a_RegWriteE, a_CondExE, a_BranchTakenE;
  logic [1:0]  a_ALUControlE;
  logic [3:0]  a_WA3E, a_WA3Mv, a_WA3W, a_FlagsQ;
  logic [0:0]  a_RegWriteMv;
  logic        a_RegWriteM, a_MemWriteM, a_MemtoRegM, a_RegWriteW, a_MemtoRegW, a_PCSrcW;
  logic [15:0] a_Ret, a_Sq;

  logic        b_ALUSrcE, b_MemtoRegE, b_RegWriteE, b_CondExE, b_BranchTakenE;
  logic [1:0]  b_ALUControlE;
  logic [3:0]  b_WA3E, b_WA3W, b_FlagsQ;
  logic [11:0] b_WA3Mv;
  logic [2:0]  b_RegWriteMv;
  logic        b_RegWriteM, b_MemWriteM, b_MemtoRegM, b_RegWriteW, b_MemtoRegW, b_PCSrcW;
  logic [3:0]  b_Ret, b_Sq;

  ctrl_path_pipe #(.MEM_STAGES(1), .ALU_CTRL_W(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWriteD(FlagWriteD), .CondD(CondD), .WA3D(WA3D), .ALUFlags(ALUFlags),
    .ALUSrcE(a_ALUSrcE), .MemtoRegE(a_MemtoRegE), .RegWriteE(a_RegWriteE),
    .ALUControlE(a_ALUControlE), .WA3E(a_WA3E), .CondExE(a_CondExE),
    .BranchTakenE(a_BranchTakenE), .RegWriteMv(a_RegWriteMv), .WA3Mv(a_WA3Mv),
    .RegWriteM(a_RegWriteM), .MemWriteM(a_MemWriteM), .MemtoRegM(a_MemtoRegM),
    .RegWriteW(a_RegWriteW), .MemtoRegW(a_MemtoRegW), .PCSrcW(a_PCSrcW), .WA3W(a_WA3W),
    .FlagsQ(a_FlagsQ), .RetireCount(a_Ret), .SquashCount(a_Sq)
  );

  ctrl_path_pipe #(.MEM_STAGES(3), .ALU_CTRL_W(2), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWriteD(FlagWriteD), .CondD(CondD), .WA3D(WA3D), .ALUFlags(ALUFlags),
    .ALUSrcE(b_ALUSrcE), .MemtoRegE(b_MemtoRegE), .RegWriteE(b_RegWriteE),
    .ALUControlE(b_ALUControlE), .WA3E(b_WA3E), .CondExE(b_CondExE),
    .BranchTakenE(b_BranchTakenE), .RegWriteMv(b_RegWriteMv), .WA3Mv(b_WA3Mv),
    .RegWriteM(b_RegWriteM), .MemWriteM(b_MemWriteM), .MemtoRegM(b_MemtoRegM),
    .RegWriteW(b_RegWriteW), .MemtoRegW(b_MemtoRegW), .PCSrcW(b_PCSrcW), .WA3W(b_WA3W),
    .FlagsQ(b_FlagsQ), .RetireCount(b_Ret), .SquashCount(b_Sq)
  );

  typedef struct packed {
    logic v, pcsrc, rw, m2r, mw, br, alusrc;
    logic [1:0] aluc;
    logic [1:0] fw;
    logic [3:0] cond;
    logic [3:0] wa3;
  } ectl_t;

  typedef struct packed {
    logic v, pcsrc, rw, m2r, mw;
    logic [3:0] wa3;
  } slot_t;

  localparam int HIST_N = 16384;

  // Model: instruction in E, flags, and what left E on each edge (index = edge number)
  ectl_t      me;
  logic [3:0] mflags;
  slot_t      hist [0:HIST_N-1];
  int         t = -1;
  int         last_rst = -100;
  int         mret1, mret3, msq;
  int         total = 0;
  int         bad = 0;
  bit         started = 1'b0;
  logic [15:0] mask;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // What left E at edge u; anything at or before the last reset edge is gone
  function automatic slot_t slot(input int u);
    if (u < 0 || u <= last_rst) return '0;
    return hist[u];
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d act=%0h exp=%0h", nm, t, act, exp);
    end
  endtask

  task automatic model_edge();
    logic  pass;
    slot_t ex;
    t++;
    if (t >= HIST_N) begin
      $display("FAIL hist_overflow edge=%0d", t);
      $fatal(1);
    end
    if (reset) begin
      me = '0; mflags = 4'h0; mret1 = 0; mret3 = 0; msq = 0;
      hist[t] = '0; last_rst = t;
      return;
    end
    pass = me.v && cond_pass(me.cond, mflags);
    mret1 += int'(slot(t - 2).v);
    mret3 += int'(slot(t - 4).v);
    if (me.v && !pass && !StallE) msq++;
    ex = '0;
    if (!(StallE && !FlushE)) begin
      ex.v = me.v; ex.pcsrc = me.pcsrc & pass; ex.rw = me.rw & pass;
      ex.mw = me.mw & pass; ex.m2r = me.m2r; ex.wa3 = me.wa3;
    end
    hist[t] = ex;
    if (pass && !StallE) begin
      if (me.fw[1]) mflags[3:2] = ALUFlags[3:2];
      if (me.fw[0]) mflags[1:0] = ALUFlags[1:0];
    end
    if (FlushE) me = '0;
    else if (!StallE) begin
      me.v = ValidD; me.pcsrc = PCSrcD; me.rw = RegWriteD; me.m2r = MemtoRegD;
      me.mw = MemWriteD; me.br = BranchD; me.alusrc = ALUSrcD; me.aluc = ALUControlD;
      me.fw = FlagWriteD; me.cond = CondD; me.wa3 = WA3D;
    end
  endtask

  task automatic check_all();
    logic        pass;
    slot_t       m1, w1, w3, s;
    logic [2:0]  rv3;
    logic [11:0] wv3;
    pass = me.v && cond_pass(me.cond, mflags);
    cmp("E_ctl_1", 32'({a_ALUSrcE, a_MemtoRegE, a_RegWriteE, a_ALUControlE, a_WA3E}),
        32'({me.alusrc, me.m2r, me.rw, me.aluc, me.wa3}));
    cmp("E_ctl_3", 32'({b_ALUSrcE, b_MemtoRegE, b_RegWriteE, b_ALUControlE, b_WA3E}),
        32'({me.alusrc, me.m2r, me.rw, me.aluc, me.wa3}));
    cmp("CondExE_1", 32'(a_CondExE), 32'(pass));
    cmp("CondExE_3", 32'(b_CondExE), 32'(pass));
    cmp("BrTaken_1", 32'(a_BranchTakenE), 32'(me.br & pass & ~StallE));
    cmp("BrTaken_3", 32'(b_BranchTakenE), 32'(me.br & pass & ~StallE));
    m1 = slot(t);
    cmp("M1_1", 32'({a_RegWriteM, a_MemWriteM, a_MemtoRegM}), 32'({m1.rw, m1.mw, m1.m2r}));
    cmp("M1_3", 32'({b_RegWriteM, b_MemWriteM, b_MemtoRegM}), 32'({m1.rw, m1.mw, m1.m2r}));
    cmp("Mv_1", 32'({a_WA3Mv, a_RegWriteMv}), 32'({m1.wa3, m1.rw}));
    rv3 = 3'b0; wv3 = 12'h0;
    for (int j = 0; j < 3; j++) begin
      s = slot(t - j);
      rv3[j] = s.rw;
      wv3[4*j +: 4] = s.wa3;
    end
    cmp("Mv_3", 32'({b_WA3Mv, b_RegWriteMv}), 32'({wv3, rv3}));
    w1 = slot(t - 1);
    w3 = slot(t - 3);
    cmp("W_1", 32'({a_RegWriteW, a_MemtoRegW, a_PCSrcW, a_WA3W}), 32'({w1.rw, w1.m2r, w1.pcsrc, w1.wa3}));
    cmp("W_3", 32'({b_RegWriteW, b_MemtoRegW, b_PCSrcW, b_WA3W}), 32'({w3.rw, w3.m2r, w3.pcsrc, w3.wa3}));
    cmp("Flags_1", 32'(a_FlagsQ), 32'(mflags));
    cmp("Flags_3", 32'(b_FlagsQ), 32'(mflags));
    cmp("Retire_1", 32'(a_Ret), 32'(mret1) & 32'hFFFF);
    cmp("Retire_3", 32'(b_Ret), 32'(mret3) & 32'hF);
    cmp("Squash_1", 32'(a_Sq), 32'(msq) & 32'hFFFF);
    cmp("Squash_3", 32'(b_Sq), 32'(msq) & 32'hF);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge
  task automatic tick();
    #1;
    if (started) check_all();
    @(posedge clk);
    model_edge();
    if (reset) started = 1'b1;
    @(negedge clk);
  endtask

  task automatic clr_d();
    ValidD = 0; PCSrcD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
    BranchD = 0; ALUSrcD = 0; ALUControlD = 2'b00; FlagWriteD = 2'b00;
    CondD = 4'h0; WA3D = 4'h0;
  endtask

  task automatic do_reset();
    clr_d(); reset = 1; StallE = 0; FlushE = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    clr_d(); reset = 1; StallE = 0; FlushE = 0; ALUFlags = 4'h0;
    me = '0; mflags = 4'h0; mret1 = 0; mret3 = 0; msq = 0;
    @(negedge clk);
    tick(); tick();
    cmp("rst_flags", 32'(a_FlagsQ), 32'd0);
    cmp("rst_rwW", 32'(a_RegWriteW), 32'd0);
    cmp("rst_ret", 32'(a_Ret), 32'd0);
    reset = 0;

    // Single ALU op through both pipelines
    ValidD = 1; RegWriteD = 1; CondD = 4'hE; WA3D = 4'd5; tick();
    cmp("t1_RegWriteE", 32'(a_RegWriteE), 32'd1);
    clr_d(); tick();
    cmp("t1_RegWriteM", 32'(a_RegWriteM), 32'd1);
    cmp("t1_Mv3_a", 32'(b_RegWriteMv), 32'b001);
    cmp("t1_WAv3_a", 32'(b_WA3Mv), 32'h005);
    tick();
    cmp("t1_RegWriteW", 32'(a_RegWriteW), 32'd1);
    cmp("t1_WA3W", 32'(a_WA3W), 32'd5);
    cmp("t1_Mv3_b", 32'(b_RegWriteMv), 32'b010);
    cmp("t1_WAv3_b", 32'(b_WA3Mv), 32'h050);
    tick();
    cmp("t1_Retire", 32'(a_Ret), 32'd1);
    cmp("t1_Mv3_c", 32'(b_RegWriteMv), 32'b100);
    cmp("t1_WAv3_c", 32'(b_WA3Mv), 32'h500);
    cmp("t1_W3_early", 32'(b_RegWriteW), 32'd0);
    tick();
    cmp("t1_W3", 32'({b_RegWriteW, b_WA3W}), 32'h15);
    tick();
    cmp("t1_Retire3", 32'(b_Ret), 32'd1);

    // CMP then BEQ, taken and not taken
    do_reset();
    ValidD = 1; FlagWriteD = 2'b11; CondD = 4'hE; tick();
    clr_d(); ValidD = 1; BranchD = 1; PCSrcD = 1; CondD = 4'h0; ALUFlags = 4'b0100; tick();
    cmp("beq_flags", 32'(a_FlagsQ), 32'b0100);
    cmp("beq_taken", 32'(a_BranchTakenE), 32'd1);
    clr_d(); ALUFlags = 4'h0; tick();
    ValidD = 1; FlagWriteD = 2'b11; CondD = 4'hE; tick();
    clr_d(); ValidD = 1; BranchD = 1; PCSrcD = 1; CondD = 4'h0; ALUFlags = 4'b0000; tick();
    cmp("bne_flags", 32'(a_FlagsQ), 32'd0);
    cmp("bne_taken", 32'(a_BranchTakenE), 32'd0);
    clr_d(); tick();
    cmp("bne_squash", 32'(a_Sq), 32'd1);

    // Condition sweep: every CondD against every flag value
    for (int f = 0; f < 16; f++) begin
      clr_d(); ValidD = 1; FlagWriteD = 2'b11; CondD = 4'hE; ALUFlags = 4'($urandom); tick();
      mask = 16'h0;
      for (int c = 0; c < 16; c++) begin
        clr_d(); ValidD = 1; CondD = 4'(c);
        ALUFlags = (c == 0) ? 4'(f) : 4'($urandom);
        tick();
        if (c == 0) cmp("sweep_flags", 32'(a_FlagsQ), 32'(f));
        if (c == 15) cmp("sweep_never", 32'(a_CondExE), 32'd0);
        mask[c] = a_CondExE;
      end
      if (f == 4)  cmp("sweep_mask_0100", 32'(mask), 32'h66A9);
      if (f == 10) cmp("sweep_mask_1010", 32'(mask), 32'h6996);
    end

    // Stall for two cycles with a flag-writing instruction in E
    do_reset();
    ValidD = 1; RegWriteD = 1; FlagWriteD = 2'b11; CondD = 4'hE; WA3D = 4'd9; tick();
    clr_d(); ValidD = 1; RegWriteD = 1; CondD = 4'hE; WA3D = 4'd3;
    StallE = 1; ALUFlags = 4'hF; tick();
    cmp("stall1_WA3E", 32'({a_RegWriteE, a_WA3E}), 32'h19);
    cmp("stall1_M1", 32'(a_RegWriteM), 32'd0);
    cmp("stall1_flags", 32'(a_FlagsQ), 32'd0);
    tick();
    cmp("stall2_WA3E", 32'({a_RegWriteE, a_WA3E}), 32'h19);
    cmp("stall2_M1", 32'(a_RegWriteM), 32'd0);
    cmp("stall2_flags", 32'(a_FlagsQ), 32'd0);
    StallE = 0; clr_d(); ALUFlags = 4'b0011; tick();
    cmp("unstall_M1", 32'(a_RegWriteM), 32'd1);
    cmp("unstall_flags", 32'(a_FlagsQ), 32'b0011);
    tick(); tick(); tick();
    cmp("stall_retire1", 32'(a_Ret), 32'd1);
    tick(); tick();
    cmp("stall_retire3", 32'(b_Ret), 32'd1);
    ValidD = 1; RegWriteD = 1; WA3D = 4'd6; CondD = 4'hE; tick();
    StallE = 1; FlushE = 1; clr_d(); tick();
    cmp("stallflush_E", 32'({a_RegWriteE, a_WA3E}), 32'd0);
    StallE = 0; FlushE = 0;

    // Reset with three instructions in flight
    do_reset();
    ValidD = 1; RegWriteD = 1; CondD = 4'hE; WA3D = 4'd1; tick();
    WA3D = 4'd2; tick();
    WA3D = 4'd3; tick();
    clr_d(); reset = 1; tick();
    cmp("rstmid_E", 32'({a_RegWriteE, a_WA3E}), 32'd0);
    cmp("rstmid_M", 32'({a_RegWriteM, b_RegWriteMv, b_WA3Mv}), 32'd0);
    cmp("rstmid_W", 32'({a_RegWriteW, a_WA3W}), 32'd0);
    cmp("rstmid_cnt", 32'({a_Ret, a_Sq, a_FlagsQ}), 32'd0);
    reset = 0;
    repeat (6) tick();
    cmp("rstmid_ret1", 32'(a_Ret), 32'd0);
    cmp("rstmid_ret3", 32'(b_Ret), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      StallE      = ($urandom_range(0, 5) == 0);
      FlushE      = ($urandom_range(0, 7) == 0);
      ValidD      = ($urandom_range(0, 3) != 0);
      PCSrcD      = 1'($urandom);
      RegWriteD   = 1'($urandom);
      MemtoRegD   = 1'($urandom);
      MemWriteD   = 1'($urandom);
      BranchD     = 1'($urandom);
      ALUSrcD     = 1'($urandom);
      ALUControlD = 2'($urandom);
      FlagWriteD  = 2'($urandom);
      CondD       = 4'($urandom);
      WA3D        = 4'($urandom);
      ALUFlags    = 4'($urandom);
      tick();
    end
    reset = 0; StallE = 0; FlushE = 0; clr_d();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
